// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchroniser, mid-bit sampling, glitch and framing checks.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_sis,
  input  logic                 rst,
  input  logic                 rx1,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // Synchroniser flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx1};
    end
  end

  assign rx_s = sync_q[1];
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            tick  <= '0;
          end
        end
        // Re-check the line half a bit in; a high level means the edge was a glitch.
        ST_START: begin
          if (tick == TICK_HALF) begin
            tick <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick == TICK_LAST) begin
            tick    <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        // Leaving mid-stop-bit lets IDLE catch a start bit that follows with no gap.
        ST_STOP: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= ^{shift, par_bit};
`endif
              state      <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receiving end of the UART link: deserialises the frames produced by the project's UART transmitter on tx1.
- Samples the serial line at mid-bit using an oversampling counter on the system clock. Outputs each received byte with a one-cycle valid strobe.
- Flags framing errors and rejects start-bit glitches.
- Sits between the serial pin and the downstream byte consumer (FIFO/register file).

Parameters:
- CLKS_PER_BIT, 4, clk_sis cycles per serial bit; even, >= 4.
- DATA_BITS, 8, data bits per frame, LSB first; range 5..8.

Ports:
- clk_sis  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, active-low asynchronous.
- rx1  input  1  serial line; idle high, start=0, DATA_BITS data LSB first, stop=1.
- data_out  output  DATA_BITS  last correctly framed byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Clock is clk_sis; reset is rst, asserted low.
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- rx1 passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Counters:
  - tick counter, 0..CLKS_PER_BIT-1.
  - bit index, 0..DATA_BITS-1.
  - shift register, DATA_BITS wide; shifts right, new bit enters at the MSB.
- State machine:
  - IDLE:
    - rx_s==1 -> stay.
    - rx_s==0 -> START, tick=0.
  - START:
    - Count to tick==CLKS_PER_BIT/2-1, then sample.
    - rx_s==0 -> DATA, tick=0, bit=0.
    - rx_s==1 -> glitch; IDLE with no pulse.
  - DATA:
    - Sample when tick==CLKS_PER_BIT-1, i.e. mid-bit; tick then resets to 0.
    - After bit DATA_BITS-1 -> STOP (or PARITY when the optional feature is on).
  - STOP:
    - Sample at tick==CLKS_PER_BIT-1.
    - rx_s==1 -> data_out<=shift, data_valid=1 for 1 cycle, then IDLE.
    - rx_s==0 -> frame_err=1 for 1 cycle, data_out unchanged, then BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line produces exactly one frame_err.
- Latency: data_valid is high in the cycle 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the first clk_sis edge that samples rx1 low.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is entered mid-stop-bit, so it sees the next falling edge.
- data_valid and frame_err never assert in the same cycle.
- Reset mid-frame aborts immediately; the partial byte is discarded and no pulse is produced.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA, sampled like a data bit; even parity is expected.
  - Extra output parity_err, 1 bit, reset 0.
  - On a good stop bit, parity mismatch -> parity_err pulse for 1 cycle together with data_valid; data_out still updates.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state and no parity_err port. Frame is start + DATA_BITS + stop.

Test Plan:
- Reset held low 3 cycles, then released with rx1=1 -> all outputs 0, busy=0 for 50 cycles.
- Frame 0x5B (bits 1,1,0,1,1,0,1,0), CLKS_PER_BIT=4 -> data_valid pulses once at cycle 40 after the start edge. data_out=8'h5B, frame_err=0.
- rx1 low for 1 cycle, then high -> busy rises briefly, returns to IDLE, no data_valid or frame_err.
- Frame 0xA5 with stop bit forced 0, line held low 20 cycles -> single frame_err pulse, data_out keeps the previous 0x5B. Then a 0x3C frame is received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses 40 cycles apart, values 8'h00 then 8'hFF.
- rst asserted low mid-data of a 0x81 frame, released, then a 0x42 frame -> no pulse for 0x81, data_out=0 after reset, 0x42 received. With UART_RX_PARITY_EN: 0x5B with parity bit 0 -> data_valid and parity_err both pulse.
